// File: rtl/des_sched_pkg.sv
// des_sched_pkg: shared types, defaults and next-chunk helper for the DES keyspace scheduler
package des_sched_pkg;
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;
  localparam int KEY_W_DEF = 56;
  localparam int CHUNK_W_DEF = 20;
  // Returns {exhausted, next_base}; keys are zero-extended to 64 bits, so a carry
  // into bit key_w is a wrap of the keyspace.
  function automatic logic [64:0] next_base(input logic [63:0] base, input logic [63:0] limit,
                                            input int key_w, input int chunk_w);
    logic [63:0] sum, mask;
    mask = (64'd1 << key_w) - 64'd1;
    sum = base + (64'd1 << chunk_w);
    return {sum[key_w] || ((sum & mask) > limit), sum & mask};
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; pointer moves past the winner only when ack_i
//   clk, reset : clock, async active-high reset
//   req_i      : request vector
//   ack_i      : the current grant was accepted this cycle
//   gnt_o      : one-hot grant (zero when no request)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         ack_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr_q, sel;
  int idx;
  // Scan from the farthest offset down so the nearest requester to the pointer wins.
  always_comb begin
    gnt_o = '0;
    sel = ptr_q;
    idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % N;
      if (req_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
        sel = PW'(idx);
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= '0;
    else if (ack_i) ptr_q <= (int'(sel) == N - 1) ? '0 : sel + 1'b1;
endmodule

// File: rtl/des_search_sched.sv
// des_search_sched: splits a key range into chunks, dispatches them to search lanes, latches the first find
//   clk, reset                    : clock, async active-high reset
//   start, abort                  : host control (start level, abort pulse)
//   base_key, limit_key           : inclusive search range, sampled when leaving IDLE
//   disp_valid/disp_ready/disp_base : per-lane chunk offer, shared base bus
//   res_valid/res_found/res_key/res_ready : per-lane result return
//   busy, done, found, found_key, chunks_issued : status
//   perf_cycles                   : active-cycle counter, present only with DES_SCHED_PERF_EN
module des_search_sched
  import des_sched_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int CHUNK_W   = CHUNK_W_DEF,
  parameter int KEY_W     = KEY_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [KEY_W-1:0]           base_key,
  input  logic [KEY_W-1:0]           limit_key,
  output logic [NUM_LANES-1:0]       disp_valid,
  input  logic [NUM_LANES-1:0]       disp_ready,
  output logic [KEY_W-1:0]           disp_base,
  input  logic [NUM_LANES-1:0]       res_valid,
  input  logic [NUM_LANES-1:0]       res_found,
  input  logic [NUM_LANES*KEY_W-1:0] res_key,
  output logic [NUM_LANES-1:0]       res_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic [31:0]                chunks_issued
`ifdef DES_SCHED_PERF_EN
  , output logic [31:0]              perf_cycles
`endif
);
  state_t state_q;
  logic [KEY_W-1:0] next_base_q, limit_q, found_key_q, rkey;
  logic [NUM_LANES-1:0] infl_q, d_gnt, r_gnt;
  logic [31:0] chunks_q;
  logic found_q, active, xfer, racc, rfound, nb_unused;
  logic [64:0] nb;
  assign active = (state_q == DISPATCH) || (state_q == DRAIN);
  // A lane is only offered a chunk when its registered in-flight flag is clear,
  // so a result accepted this cycle makes it eligible next cycle at the earliest.
  rr_arbiter #(.N(NUM_LANES)) u_disp_arb (.clk(clk), .reset(reset), .req_i(disp_ready & ~infl_q), .ack_i(xfer), .gnt_o(d_gnt));
  rr_arbiter #(.N(NUM_LANES)) u_res_arb (.clk(clk), .reset(reset), .req_i(res_valid & infl_q), .ack_i(racc), .gnt_o(r_gnt));
  assign disp_valid = (state_q == DISPATCH) ? d_gnt : '0;
  assign res_ready = active ? r_gnt : '0;
  assign xfer = |(disp_valid & disp_ready);
  assign racc = |res_ready;
  assign disp_base = next_base_q;
  assign busy = active;
  assign done = state_q == DONE;
  assign found = found_q;
  assign found_key = found_key_q;
  assign chunks_issued = chunks_q;
  assign nb = next_base(64'(next_base_q), 64'(limit_q), KEY_W, CHUNK_W);
  assign nb_unused = ^nb[63:KEY_W];
  always_comb begin
    rkey = '0;
    rfound = 1'b0;
    for (int i = 0; i < NUM_LANES; i++)
      if (res_ready[i]) begin
        rkey = res_key[i*KEY_W +: KEY_W];
        rfound = res_found[i];
      end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      next_base_q <= '0;
      limit_q <= '0;
      found_q <= 1'b0;
      found_key_q <= '0;
      chunks_q <= '0;
      infl_q <= '0;
    end else begin
      infl_q <= (infl_q | (xfer ? disp_valid : '0)) & ~res_ready;
      if (racc && rfound && !found_q) begin
        found_q <= 1'b1;
        found_key_q <= rkey;
      end
      case (state_q)
        IDLE: if (start) begin
          next_base_q <= base_key;
          limit_q <= limit_key;
          found_q <= 1'b0;
          found_key_q <= '0;
          chunks_q <= '0;
          state_q <= (base_key > limit_key) ? DONE : DISPATCH;
        end
        DISPATCH: begin
          if (xfer) begin
            next_base_q <= nb[KEY_W-1:0];
            chunks_q <= chunks_q + 32'd1;
          end
          if ((xfer && nb[64]) || (racc && rfound) || abort) state_q <= DRAIN;
        end
        DRAIN: if (infl_q == '0) state_q <= DONE;
        default: if (!start) state_q <= IDLE;
      endcase
    end
  end
`ifdef DES_SCHED_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) perf_q <= '0;
    else if (state_q == IDLE && start) perf_q <= '0;
    else if (active && perf_q != 32'hFFFF_FFFF) perf_q <= perf_q + 32'd1;
  assign perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_des_search_sched.sv
// tb_des_search_sched: directed scoreboard bench for des_search_sched with a behavioural lane model
module tb_des_search_sched;
  localparam int NL = 4, CW = 4, KW = 56;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [KW-1:0] base_key = '0, limit_key = '0, disp_base, found_key;
  logic [NL-1:0] disp_valid, disp_ready, res_valid, res_found, res_ready;
  logic [NL*KW-1:0] res_key;
  logic busy, done, found;
  logic [31:0] chunks_issued;
`ifdef DES_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif
  always #5 clk = ~clk;
  des_search_sched #(.NUM_LANES(NL), .CHUNK_W(CW), .KEY_W(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_key(base_key), .limit_key(limit_key),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_base(disp_base),
    .res_valid(res_valid), .res_found(res_found), .res_key(res_key), .res_ready(res_ready),
    .busy(busy), .done(done), .found(found), .found_key(found_key), .chunks_issued(chunks_issued)
`ifdef DES_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );
  typedef struct {int lane; logic [KW-1:0] base;} disp_t;
  disp_t exp_q[$];
  int acc_q[$];
  logic [NL-1:0] mask, lbusy, hold, lfind;
  int lcnt[NL], lat[NL];
  logic [KW-1:0] lkey[NL];
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_lanes();
    mask = '1; lbusy = '0; hold = '0; lfind = '0;
    for (int i = 0; i < NL; i++) begin lcnt[i] = 0; lat[i] = 1; lkey[i] = '0; end
  endtask

  function automatic void push(input int lane, input logic [KW-1:0] base);
    disp_t e;
    e.lane = lane; e.base = base;
    exp_q.push_back(e);
  endfunction

  // One clock: drive lane outputs, look at what the DUT will transfer on the coming edge, update the lane model.
  task automatic step();
    disp_t e;
    int ln;
    for (int i = 0; i < NL; i++) begin
      res_valid[i] = lbusy[i] && lcnt[i] == 0 && !hold[i];
      res_found[i] = lfind[i];
      res_key[i*KW +: KW] = lkey[i];
    end
    disp_ready = mask;
    #1;
    check("res_ready_legal", 64'($onehot0(res_ready) && ((res_ready & ~res_valid) == '0)), 64'd1);
    for (int i = 0; i < NL; i++) if (lbusy[i] && lcnt[i] > 0) lcnt[i]--;
    if ((disp_valid & disp_ready) != '0) begin
      ln = 0;
      for (int i = 0; i < NL; i++) if (disp_valid[i]) ln = i;
      e.lane = -1; e.base = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("disp_onehot", 64'($onehot(disp_valid)), 64'd1);
      check("disp_lane", 64'(ln), 64'(e.lane));
      check("disp_base", 64'(disp_base), 64'(e.base));
      lbusy[ln] = 1'b1;
      lcnt[ln] = lat[ln];
    end
    for (int i = 0; i < NL; i++) if (res_ready[i]) begin lbusy[i] = 1'b0; acc_q.push_back(i); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic begin_search(input logic [KW-1:0] b, input logic [KW-1:0] l);
    base_key = b; limit_key = l; start = 1'b1;
    step();
  endtask

  task automatic run_until_empty(input int bound);
    int n = 0;
    while (exp_q.size() > 0 && n < bound) begin step(); n++; end
    check("all_dispatched", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin step(); n++; end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic finish_search();
    start = 1'b0;
    step();
    check("idle_after_done", 64'(done), 64'd0);
  endtask

  initial begin
    reset_lanes();
    disp_ready = '0; res_valid = '0; res_found = '0; res_key = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_found", 64'(found), 0);
    check("rst_chunks", 64'(chunks_issued), 0);
    check("rst_disp_valid", 64'(disp_valid), 0);
    check("rst_res_ready", 64'(res_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // plain search, four chunks, no find
    reset_lanes();
    for (int i = 0; i < NL; i++) lat[i] = 2;
    push(0, 'h00); push(1, 'h10); push(2, 'h20); push(3, 'h30);
    begin_search('h0, 'h3F);
    check("t1_busy", 64'(busy), 1);
    run_until_empty(20);
    wait_done(40);
    check("t1_found", 64'(found), 0);
    check("t1_chunks", 64'(chunks_issued), 4);
    finish_search();

    // lane 2 finds while lanes 0 and 1 are still out
    reset_lanes();
    mask = 4'b0111; hold[0] = 1'b1; hold[1] = 1'b1;
    lat[2] = 0; lfind[2] = 1'b1; lkey[2] = 'h25;
    push(0, 'h00); push(1, 'h10); push(2, 'h20);
    begin_search('h0, 'hFF);
    run_until_empty(20);
    step(); step();
    mask = '1;
    step();
    check("t2_drain_no_disp", 64'(disp_valid), 0);
    check("t2_drain_busy", 64'(busy), 1);
    check("t2_drain_not_done", 64'(done), 0);
    hold = '0;
    wait_done(20);
    check("t2_found", 64'(found), 1);
    check("t2_found_key", 64'(found_key), 'h25);
    check("t2_chunks", 64'(chunks_issued), 3);
    finish_search();

    // simultaneous finds on lanes 1 and 3 with the result pointer at lane 1
    reset_lanes();
    hold = '1;
    push(3, 'h00); push(0, 'h10); push(1, 'h20); push(2, 'h30);
    begin_search('h0, 'hFF);
    run_until_empty(20);
    mask = '0;
    acc_q.delete();
    hold[0] = 1'b0;
    for (int n = 0; n < 10 && lbusy[0]; n++) step();
    hold[1] = 1'b0; hold[3] = 1'b0;
    lfind[1] = 1'b1; lkey[1] = 'h12; lfind[3] = 1'b1; lkey[3] = 'h31;
    step(); step();
    check("t3_acc_count", 64'(acc_q.size()), 3);
    check("t3_acc_first", 64'(acc_q[1]), 1);
    check("t3_acc_second", 64'(acc_q[2]), 3);
    hold[2] = 1'b0;
    wait_done(20);
    check("t3_found", 64'(found), 1);
    check("t3_found_key", 64'(found_key), 'h12);
    check("t3_chunks", 64'(chunks_issued), 4);
    finish_search();

    // keyspace wrap ends after one chunk
    reset_lanes();
    push(3, 56'hFF_FFFF_FFFF_FFF0);
    begin_search(56'hFF_FFFF_FFFF_FFF0, '1);
    run_until_empty(10);
    wait_done(20);
    check("t4_chunks", 64'(chunks_issued), 1);
    check("t4_found", 64'(found), 0);
    finish_search();

    // abort after two dispatches
    reset_lanes();
    hold = '1; mask = 4'b0011;
    push(0, 'h00); push(1, 'h10);
    begin_search('h0, 'hFFF);
    run_until_empty(10);
    abort = 1'b1;
    step();
    abort = 1'b0; mask = '1;
    step();
    check("t5_drain_busy", 64'(busy), 1);
    check("t5_no_disp", 64'(disp_valid), 0);
    check("t5_not_done", 64'(done), 0);
    hold = '0;
    wait_done(20);
    check("t5_found", 64'(found), 0);
    check("t5_chunks", 64'(chunks_issued), 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort_in_done", 64'(done), 1);
    finish_search();

    // async reset in DRAIN, then a clean search
    reset_lanes();
    hold[2] = 1'b1; hold[0] = 1'b1;
    lat[3] = 0; lfind[3] = 1'b1; lkey[3] = 'h3A;
    push(2, 'h00); push(3, 'h10); push(0, 'h20);
    begin_search('h0, 'hFF);
    run_until_empty(20);
    step();
    check("t6_drain_busy", 64'(busy), 1);
    check("t6_found", 64'(found), 1);
    check("t6_found_key", 64'(found_key), 'h3A);
    check("t6_chunks", 64'(chunks_issued), 3);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy", 64'(busy), 0);
    check("t6_rst_done", 64'(done), 0);
    check("t6_rst_found", 64'(found), 0);
    check("t6_rst_found_key", 64'(found_key), 0);
    check("t6_rst_chunks", 64'(chunks_issued), 0);
    check("t6_rst_disp_base", 64'(disp_base), 0);
    check("t6_rst_res_ready", 64'(res_ready), 0);
    reset_lanes();
    exp_q.delete();
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push(0, 'h100); push(1, 'h110);
    begin_search('h100, 'h11F);
    run_until_empty(10);
    wait_done(20);
    check("t6_new_chunks", 64'(chunks_issued), 2);
    check("t6_new_found", 64'(found), 0);
    finish_search();

    // empty range goes straight to DONE
    reset_lanes();
    begin_search('h5, 'h4);
    check("t7_done", 64'(done), 1);
    check("t7_busy", 64'(busy), 0);
    check("t7_chunks", 64'(chunks_issued), 0);
    finish_search();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/des_search_sched.md
Name: des_search_sched

Overview:
- Keyspace scheduler for the DES key-search engine.
- Splits a 56-bit key range into fixed-size chunks and dispatches them to NUM_LANES parallel search lanes. Each lane is a counter + parity + DES + compare datapath.
- Collects per-lane results and latches the first matching key.
- Stops dispatching on a find or an abort, drains outstanding lanes, then reports completion to the host.

Parameters:
- NUM_LANES, 4, number of search lanes (2..16).
- CHUNK_W, 20, log2 of keys per chunk; chunk size = 2^CHUNK_W.
- KEY_W, 56, raw key width (parity bits excluded).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; rising from IDLE begins a search; must be held until done is seen.
- abort  in  1  single-cycle pulse; terminate the search without a find.
- base_key  in  KEY_W  first key of the search; sampled on leaving IDLE.
- limit_key  in  KEY_W  last key of the search, inclusive; sampled on leaving IDLE.
- disp_valid  out  NUM_LANES  one-hot; chunk offer to lane i.
- disp_ready  in  NUM_LANES  lane i is able to accept a chunk.
- disp_base  out  KEY_W  chunk start key; shared bus for all lanes.
- res_valid  in  NUM_LANES  lane i has finished its chunk.
- res_found  in  NUM_LANES  lane i's chunk contained a match.
- res_key  in  NUM_LANES*KEY_W  matching key, lane i at bits [i*KEY_W +: KEY_W].
- res_ready  out  NUM_LANES  one-hot; result accept for lane i.
- busy  out  1  high in DISPATCH and DRAIN.
- done  out  1  high in DONE.
- found  out  1  a match was latched; meaningful while done.
- found_key  out  KEY_W  the latched matching key.
- chunks_issued  out  32  number of chunks dispatched in the current search.

Behaviour:
- Reset: FSM to IDLE. All outputs 0; in-flight flags, next_base and chunks_issued cleared.
- States: IDLE, DISPATCH, DRAIN, DONE.
- IDLE:
  - On start=1, latch base_key into next_base and limit_key into limit_r, clear found/found_key/chunks_issued, go to DISPATCH.
  - If base_key > limit_key, go straight to DONE with found=0.
- DISPATCH:
  - Eligible lanes: disp_ready=1 and registered in-flight flag=0.
  - A round-robin arbiter selects at most one lane per cycle; disp_valid is one-hot to that lane and disp_base = next_base.
  - Transfer occurs when disp_valid & disp_ready in the same cycle. On transfer: set the lane's in-flight flag, next_base += 2^CHUNK_W, chunks_issued += 1.
  - Exhausted when the increment carries out of KEY_W (wrap-around) or the new next_base > limit_r. Chunks are not trimmed: the last chunk may run past limit_key, and lanes are responsible for honouring the range.
  - Transitions: exhausted, or a found result accepted, or abort → DRAIN.
- Result side (DISPATCH and DRAIN):
  - An independent round-robin arbiter drives res_ready one-hot to one lane that has res_valid=1.
  - On accept: clear that lane's in-flight flag.
  - If res_found=1 and found=0, latch found=1 and found_key=res_key[lane]. Later finds are discarded; first accepted wins.
- Same-cycle result and dispatch on one lane: the result clears in-flight, but the lane is not eligible for dispatch until the next cycle.
- DRAIN: no dispatch (disp_valid=0). When all in-flight flags are 0 → DONE.
- DONE: done=1, found and found_key held. When start=0 → IDLE.
- abort:
  - In IDLE or DONE: ignored.
  - In DRAIN: no effect beyond what is already happening.
- res_valid from a lane that is not in flight: ignored, res_ready stays low for it.
- reset asserted mid-search: immediate return to IDLE; lanes are reset by the same signal.

Optional Feature:
- Macro: DES_SCHED_PERF_EN.
- Defined: adds output perf_cycles[31:0].
  - Cleared on leaving IDLE.
  - Counts every cycle in DISPATCH or DRAIN.
  - Saturates at 32'hFFFFFFFF and holds through DONE.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- des_sched_pkg holds:
  - the state enum (IDLE, DISPATCH, DRAIN, DONE) as 2-bit logic;
  - KEY_W_DEF=56 and CHUNK_W_DEF=20;
  - the function that computes the next base and its exhausted flag.
- Sub-module rr_arbiter #(N): request vector in, one-hot grant out. The pointer advances past the granting lane only on an accepted grant. Instantiated twice, once for dispatch and once for results.

Test Plan:
- Search with NUM_LANES=4, CHUNK_W=4, base=0, limit=0x3F, all lanes ready, res_found=0:
  - 4 chunks issued to lanes 0,1,2,3 with disp_base 0x00, 0x10, 0x20, 0x30;
  - after all results return, done=1, found=0, chunks_issued=4.
- Lane 2 returns res_found=1 with key 0x25 while lanes 0 and 1 are still in flight:
  - no further disp_valid;
  - DRAIN until lanes 0 and 1 return;
  - done with found_key=0x25.
- Lanes 1 and 3 assert res_found in the same cycle, keys 0x12 and 0x31, arbiter pointer at lane 1:
  - found_key=0x12;
  - lane 3's find is accepted next cycle and discarded.
- Wrap-around: base=56'hFFFFFFFFFFFFF0, limit=all-ones, CHUNK_W=4:
  - exactly 1 chunk issued;
  - DONE after its result, chunks_issued=1.
- abort pulse after 2 dispatches:
  - no more dispatches;
  - DONE once 2 results return, found=0.
- reset asserted in DRAIN:
  - all outputs 0 asynchronously;
  - a new start runs a clean search with chunks_issued restarting from 0.
